multi_ch_aggregator: RTL

//  Parametrised N-channel packet aggregator, successor to the two-engine aggregator.
//  - Round-robin arbitrates length-prefixed packets from NUM_CH engines.
//  - Packs each packet's payload back-to-back at GRAN-byte granularity into dense DATA_W output beats.
//  - Sits between the engine array and the downstream writer; valid/ready on every side.

---
 rtl/multi_ch_aggregator.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/multi_ch_aggregator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : multi_ch_aggregator
// Purpose  : N-channel round-robin packet aggregator that packs length-prefixed
//            payloads into dense output beats at GRAN-byte granularity.
//            Optional idle-timeout flush via AGG_TIMEOUT_FLUSH_EN.
// Revision : 1.0  initial release
// ============================================================================
module multi_ch_aggregator #(
  parameter int NUM_CH        = 2,
  parameter int DATA_W        = 256,
  parameter int LEN_W         = 32,
  parameter int GRAN          = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err_len
);

  localparam int c_BYTES  = DATA_W / 8;
  localparam int c_BPB    = c_BYTES / GRAN;
  localparam int c_GW     = GRAN * 8;
  localparam int c_FW     = $clog2(2 * c_BPB + 1);
  localparam int c_CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_MINLEN = LEN_W / 8;

`ifdef AGG_TIMEOUT_FLUSH_EN
  typedef enum logic [1:0] {ST_ARB = 2'd0, ST_PKT = 2'd1, ST_FLUSH = 2'd2} state_t;
  localparam int c_IW = $clog2(FLUSH_TIMEOUT + 1);
  logic [c_IW-1:0] r_idle;
`else
  typedef enum logic [1:0] {ST_ARB = 2'd0, ST_PKT = 2'd1} state_t;
`endif

  state_t                r_state, w_next;
  logic [c_CHW-1:0]      r_grant, r_rr, w_pick, w_rr_next;
  logic [c_CHW:0]        w_idx;
  logic                  w_any;
  logic                  r_first;
  logic [LEN_W-1:0]      r_rem;
  logic [2*DATA_W-1:0]   r_acc, w_acc_p, w_app;
  logic [c_FW-1:0]       r_fill, w_fill_p, w_blocks;
  logic                  r_err;
  logic [DATA_W-1:0]     w_ch_data [NUM_CH];
  logic [DATA_W-1:0]     w_beat, w_keep;
  logic [LEN_W-1:0]      w_hdr, w_len, w_remain;
  logic                  w_short, w_last, w_in_ok, w_accept, w_pop;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_ch_data[g] = in_data[g*DATA_W +: DATA_W];
  end

  // First valid channel at or after the round-robin pointer, wrapping.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_rr;
    w_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = {1'b0, r_rr} + (c_CHW+1)'(i);
      if (w_idx >= (c_CHW+1)'(NUM_CH))
        w_idx = w_idx - (c_CHW+1)'(NUM_CH);
      if (!w_any && in_valid[w_idx[c_CHW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[c_CHW-1:0];
      end
    end
  end

  assign w_rr_next = (r_grant == c_CHW'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;

  assign w_beat   = w_ch_data[r_grant];
  assign w_hdr    = w_beat[DATA_W-1 -: LEN_W];
  assign w_short  = w_hdr < LEN_W'(c_MINLEN);
  assign w_len    = w_short ? LEN_W'(c_MINLEN) : w_hdr;
  assign w_remain = r_first ? w_len : r_rem;
  assign w_last   = w_remain <= LEN_W'(c_BYTES);
  assign w_blocks = w_last ? c_FW'((w_remain + LEN_W'(GRAN - 1)) / LEN_W'(GRAN))
                           : c_FW'(c_BPB);
  // Zero the trailing bytes of a short last beat so they never pollute residue.
  assign w_keep   = ~({DATA_W{1'b1}} >> (32'(w_blocks) * c_GW));

  assign w_in_ok  = (r_state == ST_PKT) && (r_fill <= c_FW'(c_BPB));
  assign in_ready = w_in_ok ? (NUM_CH'(1) << r_grant) : '0;
  assign w_accept = w_in_ok && in_valid[r_grant];

`ifdef AGG_TIMEOUT_FLUSH_EN
  assign out_valid = (r_fill >= c_FW'(c_BPB)) || (r_state == ST_FLUSH);
`else
  assign out_valid = (r_fill >= c_FW'(c_BPB));
`endif
  assign out_data = r_acc[2*DATA_W-1 -: DATA_W];
  assign w_pop    = out_valid && out_ready;
  assign err_len  = r_err;

  // Pop first, then append at the post-pop offset; the accept gate keeps this in range.
  assign w_acc_p  = w_pop ? (r_acc << DATA_W) : r_acc;
  assign w_fill_p = !w_pop ? r_fill :
                    (r_fill >= c_FW'(c_BPB)) ? r_fill - c_FW'(c_BPB) : '0;
  assign w_app    = {w_beat & w_keep, {DATA_W{1'b0}}} >> (32'(w_fill_p) * c_GW);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_ARB;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ARB: begin
        if (w_any)
          w_next = ST_PKT;
`ifdef AGG_TIMEOUT_FLUSH_EN
        else if ((r_idle == c_IW'(FLUSH_TIMEOUT)) && (r_fill != '0) &&
                 (r_fill < c_FW'(c_BPB)))
          w_next = ST_FLUSH;
`endif
      end
      ST_PKT: if (w_accept && w_last) w_next = ST_ARB;
`ifdef AGG_TIMEOUT_FLUSH_EN
      ST_FLUSH: if (w_pop) w_next = ST_ARB;
`endif
      default: w_next = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_fill  <= '0;
      r_grant <= '0;
      r_rr    <= '0;
      r_first <= 1'b0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_acc  <= w_accept ? (w_acc_p | w_app) : w_acc_p;
      r_fill <= w_fill_p + (w_accept ? w_blocks : c_FW'(0));
      r_err  <= w_accept && r_first && w_short;
      if ((r_state == ST_ARB) && w_any) begin
        r_grant <= w_pick;
        r_first <= 1'b1;
      end
      if (w_accept) begin
        r_first <= 1'b0;
        r_rem   <= w_remain - LEN_W'(c_BYTES);
        if (w_last) r_rr <= w_rr_next;
      end
    end
  end

`ifdef AGG_TIMEOUT_FLUSH_EN
  always_ff @(posedge clk) begin
    if (reset || (r_state != ST_ARB) || (|in_valid))
      r_idle <= '0;
    else if (r_idle != c_IW'(FLUSH_TIMEOUT))
      r_idle <= r_idle + 1'b1;
  end
`endif

endmodule
`default_nettype wire
